tft_arbiter: RTL and testbench

Shares the single TFT byte transmitter between up to `N` drawing blocks (sprite drawer, maze-tile drawer, screen clear, ...). Each drawer sees a private copy of the transmitter handshake (`transmit`/`dc`/`data` out, `busy` in), unchanged from driving the transmitter directly. The arbiter grants whole transactions, so one drawer's window commands (0x2A/0x2B/0x2C) and pixel stream are never interleaved with another's. Grants rotate round-robin; a watchdog revokes stalled owners.

---
 rtl/tft_pkg.sv | 28 ++
 rtl/tft_arbiter_rr_picker.sv | 37 +++
 rtl/tft_arbiter.sv | 114 +++++++++++
 tb/tb_tft_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tft_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tft_pkg
// Brief   : Shared types and constants for the TFT transmitter arbiter and
//           the drawing blocks that share the transmitter.
// Revision: 1.0 - initial release
// ============================================================================
package tft_pkg;

  // Arbiter states, explicitly encoded
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DRAIN = 2'd2
  } tft_state_e;

  // TFT window / memory-write commands used by the drawers
  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  // Index width for n requesters; never narrower than one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tft_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module  : rr_picker
// Brief   : Combinational rotate-priority encoder. Picks the first set
//           request bit after `last`, wrapping modulo N.
// Revision: 1.0 - initial release
// ============================================================================
module rr_picker
  import tft_pkg::*;
#(
  parameter int N = 4,
  localparam int W = idx_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] sel,
  output logic         valid
);

  int w_best;

  // Choose the requester with the smallest rotated distance from last+1
  always_comb begin
    sel    = '0;
    valid  = 1'b0;
    w_best = N;
    for (int i = 0; i < N; i++) begin
      if (req[i] && (((i - int'(last) - 1 + 2 * N) % N) < w_best)) begin
        w_best = (i - int'(last) - 1 + 2 * N) % N;
        sel    = W'(i);
        valid  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/tft_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tft_arbiter
// Brief   : Round-robin, whole-transaction arbiter sharing one TFT byte
//           transmitter among N drawers, with an idle watchdog that revokes
//           stalled owners.
// Revision: 1.0 - initial release
// ============================================================================
module tft_arbiter
  import tft_pkg::*;
#(
  parameter int N       = 4,
  parameter int TIMEOUT = 1024,
  localparam int W      = idx_width(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   grant,
  input  logic [N-1:0]   req_transmit,
  input  logic [N-1:0]   req_dc,
  input  logic [8*N-1:0] req_data,
  output logic [N-1:0]   req_tft_busy,
  input  logic           tft_busy,
  output logic           tft_transmit,
  output logic           tft_dc,
  output logic [7:0]     tft_data,
  output logic [W-1:0]   owner,
  output logic           active,
  output logic           timeout_flag
);

  localparam logic [15:0] c_TIMEOUT = 16'(TIMEOUT);

  tft_state_e   r_state;
  logic [15:0]  r_wd;
  logic [W-1:0] w_sel;
  logic         w_valid;
  logic         w_activity;
  logic         w_expire;

  rr_picker #(.N(N)) u_picker (
    .req   (req),
    .last  (owner),
    .sel   (w_sel),
    .valid (w_valid)
  );

  // Grant is zero outside GRANT, so gating by it also blanks DRAIN and reset
  assign tft_transmit = |(grant & req_transmit);
  assign tft_dc       = |(grant & req_dc);

  // Byte mux: only the granted lane can contribute
  always_comb begin
    tft_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) tft_data = tft_data | req_data[8*i +: 8];
    end
  end

  // Non-owners always see a busy transmitter so they simply wait
  for (genvar i = 0; i < N; i++) begin : g_busy
    assign req_tft_busy[i] = grant[i] ? tft_busy : 1'b1;
  end

  // A strobe or a busy transmitter counts as progress for the watchdog
  assign w_activity = tft_transmit | tft_busy;
  assign w_expire   = (TIMEOUT != 0) && (r_state == ST_GRANT) && !w_activity
                      && ((r_wd + 16'd1) == c_TIMEOUT);

  // Arbitration FSM with registered grant/owner/active/timeout outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      grant        <= '0;
      owner        <= W'(N - 1);
      active       <= 1'b0;
      timeout_flag <= 1'b0;
      r_wd         <= '0;
    end else begin
      timeout_flag <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            grant   <= N'(1) << w_sel;
            owner   <= w_sel;
            active  <= 1'b1;
            r_wd    <= '0;
            r_state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (!req[owner] || w_expire) begin
            grant        <= '0;
            active       <= 1'b0;
            timeout_flag <= w_expire;
            r_state      <= ST_DRAIN;
          end else if (w_activity) begin
            r_wd <= '0;
          end else begin
            r_wd <= r_wd + 16'd1;
          end
        end
        ST_DRAIN: begin
          // Never hand over while a byte is still in flight
          if (!tft_busy) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tft_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_tft_arbiter
// Brief   : Self-checking bench for tft_arbiter (N=4, TIMEOUT=16).
// Revision: 1.0 - initial release
// ============================================================================
module tb_tft_arbiter;

  localparam int N = 4;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req;
  logic [N-1:0]  grant;
  logic [N-1:0]  req_transmit;
  logic [N-1:0]  req_dc;
  logic [8*N-1:0] req_data;
  logic [N-1:0]  req_tft_busy;
  logic          tft_busy;
  logic          tft_transmit;
  logic          tft_dc;
  logic [7:0]    tft_data;
  logic [1:0]    owner;
  logic          active;
  logic          timeout_flag;

  tft_arbiter #(.N(N), .TIMEOUT(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .grant        (grant),
    .req_transmit (req_transmit),
    .req_dc       (req_dc),
    .req_data     (req_data),
    .req_tft_busy (req_tft_busy),
    .tft_busy     (tft_busy),
    .tft_transmit (tft_transmit),
    .tft_dc       (tft_dc),
    .tft_data     (tft_data),
    .owner        (owner),
    .active       (active),
    .timeout_flag (timeout_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  rtx;
    logic [3:0]  rdc;
    logic [31:0] rdata;
    logic        busy;
    logic        exp_tx;
    logic        exp_dc;
    logic [7:0]  exp_data;
    logic [3:0]  exp_rbusy;
  } vec_t;

  localparam logic [8:0] BYTES [14] = '{
    9'h02A, 9'h100, 9'h100, 9'h100, 9'h17F,
    9'h02B, 9'h100, 9'h100, 9'h100, 9'h19F,
    9'h02C, 9'h1F8, 9'h100, 9'h11F
  };

  int         nvec = 0;
  int         nmis = 0;
  logic [8:0] sb[$];
  vec_t       tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Every byte reaching the transmitter must be the next expected one
  task automatic monitor();
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (rst && tft_transmit) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_byte", {23'd0, tft_dc, tft_data}, 32'h1FF);
        end else begin
          e = sb.pop_front();
          check("sb_byte", {23'd0, tft_dc, tft_data}, {23'd0, e});
        end
      end
    end
  endtask

  // Wait (bounded) for a nonzero grant, then check value and latency
  task automatic wait_grant(input string name, input logic [3:0] exp, input int exp_lat);
    int n;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n++;
      if (grant != '0) break;
    end
    check(name, {28'd0, grant}, {28'd0, exp});
    check({name, "_latency"}, n, exp_lat);
  endtask

  initial begin
    int bad;
    int bad1;

    tbl[0] = '{4'b0001, 4'b0001, 32'h0000_002A, 1'b0, 1'b1, 1'b1, 8'h2A, 4'b1110};
    tbl[1] = '{4'b0000, 4'b0001, 32'h0000_0011, 1'b1, 1'b0, 1'b1, 8'h11, 4'b1111};
    tbl[2] = '{4'b1000, 4'b1000, 32'hAA00_0000, 1'b0, 1'b0, 1'b0, 8'h00, 4'b1110};
    tbl[3] = '{4'b1001, 4'b1000, 32'hAA00_0055, 1'b0, 1'b1, 1'b0, 8'h55, 4'b1110};
    tbl[4] = '{4'b0100, 4'b0000, 32'h00AA_0000, 1'b0, 1'b0, 1'b0, 8'h00, 4'b1110};
    tbl[5] = '{4'b0001, 4'b0001, 32'h0000_002C, 1'b1, 1'b1, 1'b1, 8'h2C, 4'b1111};

    rst = 1'b0; req = 4'b0101; req_transmit = '0; req_dc = '0;
    req_data = '0; tft_busy = 1'b0;
    fork monitor(); join_none

    // Reset values
    #12;
    check("rst_grant", {28'd0, grant}, 32'd0);
    check("rst_tx", {31'd0, tft_transmit}, 32'd0);
    check("rst_rbusy", {28'd0, req_tft_busy}, 32'hF);
    check("rst_owner", {30'd0, owner}, 32'd3);
    check("rst_active_flag", {30'd0, active, timeout_flag}, 32'd0);

    // Reset release with 0101 pending: requester 0 one cycle later
    cyc(); rst = 1'b1;
    @(negedge clk);
    check("first_grant_pre", {28'd0, grant}, 32'd0);
    @(negedge clk);
    check("first_grant", {28'd0, grant}, 32'b0001);
    check("first_owner", {30'd0, owner}, 32'd0);
    check("first_active", {31'd0, active}, 32'd1);

    // Mux vectors while requester 0 owns the transmitter
    for (int r = 0; r < 6; r++) begin
      cyc();
      req_transmit = tbl[r].rtx; req_dc = tbl[r].rdc;
      req_data = tbl[r].rdata; tft_busy = tbl[r].busy;
      if (tbl[r].rtx[0]) sb.push_back({tbl[r].rdc[0], tbl[r].rdata[7:0]});
      @(negedge clk);
      check($sformatf("vec%0d_tx", r), {31'd0, tft_transmit}, {31'd0, tbl[r].exp_tx});
      check($sformatf("vec%0d_dc", r), {31'd0, tft_dc}, {31'd0, tbl[r].exp_dc});
      check($sformatf("vec%0d_data", r), {24'd0, tft_data}, {24'd0, tbl[r].exp_data});
      check($sformatf("vec%0d_rbusy", r), {28'd0, req_tft_busy}, {28'd0, tbl[r].exp_rbusy});
    end

    // Drop req[0] while busy: drain, then requester 2
    cyc(); req = 4'b0100; req_transmit = '0; req_dc = '0; req_data = '0; tft_busy = 1'b1;
    @(negedge clk);
    check("drop_same_cycle_grant", {28'd0, grant}, 32'b0001);
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      cyc();
      @(negedge clk);
      if (grant != 4'b0000 || active != 1'b0) bad++;
    end
    check("drain_busy_grant", bad, 0);
    cyc(); tft_busy = 1'b0;
    @(negedge clk);
    check("drain_idle_grant", {28'd0, grant}, 32'd0);
    wait_grant("grant_req2", 4'b0100, 2);
    check("owner_req2", {30'd0, owner}, 32'd2);

    // Requester 1 takes over and streams 14 bytes; requester 2 rejoins midway
    cyc(); req = 4'b0010;
    @(negedge clk);
    check("hold_req2", {28'd0, grant}, 32'b0100);
    wait_grant("grant_req1", 4'b0010, 3);
    bad = 0; bad1 = 0;
    for (int b = 0; b < 14; b++) begin
      cyc();
      if (b == 5) req[2] = 1'b1;
      req_transmit[1] = 1'b1; req_dc[1] = BYTES[b][8];
      req_data[15:8] = BYTES[b][7:0]; tft_busy = 1'b0;
      sb.push_back(BYTES[b]);
      @(negedge clk);
      if (req_tft_busy[2] !== 1'b1) bad++;
      for (int c = 1; c <= 3; c++) begin
        cyc();
        req_transmit = '0; tft_busy = (c < 3);
        @(negedge clk);
        if (req_tft_busy[2] !== 1'b1) bad++;
        if (req_tft_busy[1] !== (c < 3)) bad1++;
      end
    end
    check("stream_rbusy2_held", bad, 0);
    check("stream_rbusy1_view", bad1, 0);
    check("stream_sb_drained", sb.size(), 0);

    // Release 1 -> 2 wins; 2 then stalls and the watchdog revokes it
    cyc(); req = 4'b1100; req_dc = '0; req_data = '0;
    @(negedge clk);
    check("hold_req1", {28'd0, grant}, 32'b0010);
    wait_grant("grant_req2b", 4'b0100, 3);
    bad = 0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (grant != 4'b0100 || timeout_flag != 1'b0) bad++;
    end
    check("wd_hold", bad, 0);
    @(negedge clk);
    check("wd_grant", {28'd0, grant}, 32'd0);
    check("wd_flag", {31'd0, timeout_flag}, 32'd1);
    req = 4'b1000;
    @(negedge clk);
    check("wd_flag_pulse", {31'd0, timeout_flag}, 32'd0);
    wait_grant("grant_req3", 4'b1000, 1);

    // Owner 3 strobes RAMWR and drops req in the same cycle, busy for 8
    cyc(); req = 4'b0001; req_transmit = 4'b1000; req_dc = 4'b0000;
    req_data = {8'h2C, 8'hAA, 8'hAA, 8'hAA}; tft_busy = 1'b0;
    sb.push_back({1'b0, 8'h2C});
    @(negedge clk);
    check("last_byte_tx", {31'd0, tft_transmit}, 32'd1);
    check("last_byte_data", {24'd0, tft_data}, 32'h2C);
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      cyc(); req_transmit = '0; req_data = '0; tft_busy = 1'b1;
      @(negedge clk);
      if (grant != 4'b0000) bad++;
    end
    check("inflight_no_grant", bad, 0);
    cyc(); tft_busy = 1'b0;
    @(negedge clk);
    check("busy_fall_grant", {28'd0, grant}, 32'd0);
    wait_grant("grant_after_busy", 4'b0001, 2);

    // Asynchronous reset during GRANT
    cyc(); req_transmit = 4'b0001; req_data = 32'h0000_0077;
    #1;
    check("pre_rst_tx", {31'd0, tft_transmit}, 32'd1);
    #1 rst = 1'b0;
    #1;
    check("async_rst_grant", {28'd0, grant}, 32'd0);
    check("async_rst_tx", {31'd0, tft_transmit}, 32'd0);
    check("async_rst_rbusy", {28'd0, req_tft_busy}, 32'hF);
    check("async_rst_owner", {30'd0, owner}, 32'd3);
    req_transmit = '0; req_data = '0; req = 4'b1001;
    cyc(); rst = 1'b1;
    @(negedge clk);
    check("post_rst_idle", {28'd0, grant}, 32'd0);
    wait_grant("post_rst_grant", 4'b0001, 1);
    check("post_rst_owner", {30'd0, owner}, 32'd0);

    check("sb_empty_end", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
`default_nettype wire
